// File: rtl/refresh_sched.sv
// Frame refresh scheduler: issues one start pulse to all layer channels,
// honouring a frame-rate cap, the WS281x latch gap and an optional keep-alive.
module refresh_sched #(
  parameter int CNT_W          = 24,
  parameter int MIN_PERIOD_CYC = 1000000,
  parameter int LATCH_CYC      = 20000,
  parameter int KEEPALIVE_CYC  = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       frame_done_i,
  input  logic [7:0] busy_i,
  output logic       refresh_o,
  output logic       keepalive_o,
  output logic       pending_o,
  output logic       drop_o,
  output logic       idle_o
);

  localparam logic [CNT_W-1:0] PER_MAX   = CNT_W'(MIN_PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] LATCH_MAX = CNT_W'((LATCH_CYC == 0) ? 0 : LATCH_CYC - 1);
  localparam logic [CNT_W-1:0] KA_MAX    = CNT_W'((KEEPALIVE_CYC == 0) ? 0 : KEEPALIVE_CYC - 1);
  localparam logic             KA_EN     = (KEEPALIVE_CYC != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_SEND,
    S_LATCH
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_ka_cnt;
  logic [CNT_W-1:0] r_lat_cnt;
  logic             r_pending;
  logic             r_refresh;
  logic             r_keepalive;
  logic             r_drop;

  logic w_busy_any;
  logic w_period_ok;
  logic w_ka_due;
  logic w_issue;
  logic w_issue_ka;

  assign w_busy_any  = |busy_i;
  assign w_period_ok = (r_per_cnt == PER_MAX);
  assign w_ka_due    = KA_EN && (r_ka_cnt == KA_MAX);
  assign w_issue     = (r_state == S_IDLE) && enable_i && w_period_ok && (r_pending || w_ka_due);
  // A new frame always wins over a keep-alive re-send.
  assign w_issue_ka  = w_issue && !r_pending;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_next = S_ARM;
      S_ARM:   w_next = S_SEND;
      S_SEND:  if (!w_busy_any) w_next = S_LATCH;
      S_LATCH: begin
        if (w_busy_any) w_next = S_SEND;
        else if (r_lat_cnt == LATCH_MAX) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_per_cnt   <= PER_MAX;
      r_ka_cnt    <= '0;
      r_lat_cnt   <= '0;
      r_pending   <= 1'b0;
      r_refresh   <= 1'b0;
      r_keepalive <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_refresh   <= w_issue;
      r_keepalive <= w_issue_ka;
      // Overwrite only counts when the waiting frame is not consumed this cycle.
      r_drop      <= frame_done_i && r_pending && !w_issue;

      if (frame_done_i) r_pending <= 1'b1;
      else if (w_issue && !w_issue_ka) r_pending <= 1'b0;

      if (w_issue) r_per_cnt <= '0;
      else if (r_per_cnt != PER_MAX) r_per_cnt <= r_per_cnt + 1'b1;

      if (w_issue || frame_done_i) r_ka_cnt <= '0;
      else if (r_state == S_IDLE && r_ka_cnt != KA_MAX) r_ka_cnt <= r_ka_cnt + 1'b1;

      // Held at 0 outside LATCH so every entry (including after a busy re-assert) restarts.
      if (r_state == S_LATCH && w_next == S_LATCH) r_lat_cnt <= r_lat_cnt + 1'b1;
      else r_lat_cnt <= '0;
    end
  end

  assign refresh_o   = r_refresh;
  assign keepalive_o = r_keepalive;
  assign pending_o   = r_pending;
  assign drop_o      = r_drop;
  assign idle_o      = (r_state == S_IDLE);

endmodule

// File: tb/tb_refresh_sched.sv
// Bench for refresh_sched: per-cycle vector table plus directed multi-cycle sequences.
module tb_refresh_sched;

  logic       clk;
  logic       rst;
  logic       en;
  logic       fd;
  logic [7:0] busy;

  logic refresh, keepalive, pending, drop, idle;
  logic ka_refresh, ka_keepalive, ka_pending, ka_drop, ka_idle;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int q_ref[$];
  int q_drop[$];
  int q_kt[$];
  bit q_kk[$];

  refresh_sched #(
    .CNT_W(24), .MIN_PERIOD_CYC(100), .LATCH_CYC(10), .KEEPALIVE_CYC(0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .frame_done_i(fd), .busy_i(busy),
    .refresh_o(refresh), .keepalive_o(keepalive), .pending_o(pending),
    .drop_o(drop), .idle_o(idle)
  );

  refresh_sched #(
    .CNT_W(24), .MIN_PERIOD_CYC(20), .LATCH_CYC(4), .KEEPALIVE_CYC(50)
  ) dut_ka (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .frame_done_i(fd), .busy_i(busy),
    .refresh_o(ka_refresh), .keepalive_o(ka_keepalive), .pending_o(ka_pending),
    .drop_o(ka_drop), .idle_o(ka_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (refresh === 1'b1) q_ref.push_back(cyc);
    if (drop === 1'b1) q_drop.push_back(cyc);
    if (ka_refresh === 1'b1) begin
      q_kt.push_back(cyc);
      q_kk.push_back(ka_keepalive);
    end
  end

  typedef struct {
    bit         rst_before;
    int         n;
    logic       en;
    logic       fd;
    logic [7:0] busy;
    logic [4:0] exp;   // {refresh, keepalive, pending, drop, idle}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rb, int n, logic e, logic f, logic [7:0] b, logic [4:0] x);
    vec_t v;
    v.rst_before = rb; v.n = n; v.en = e; v.fd = f; v.busy = b; v.exp = x;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    fd   = 1'b0;
    busy = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    q_ref.delete();
    q_drop.delete();
    q_kt.delete();
    q_kk.delete();
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual %0d required %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({refresh, keepalive, pending, drop, idle});
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; fd = 1'b0; busy = 8'h00;

    // Single frame (frame at 5, busy 8..49), then rate cap (frames at 5 and 20).
    tbl.push_back(mk(1,  5, 1, 0, 8'h00, 5'b00001));
    tbl.push_back(mk(0,  1, 1, 1, 8'h00, 5'b00001));
    tbl.push_back(mk(0,  1, 1, 0, 8'h00, 5'b00101));
    tbl.push_back(mk(0,  1, 1, 0, 8'h00, 5'b10000));
    tbl.push_back(mk(0, 42, 1, 0, 8'hFF, 5'b00000));
    tbl.push_back(mk(0, 11, 1, 0, 8'h00, 5'b00000));
    tbl.push_back(mk(0,  5, 1, 0, 8'h00, 5'b00001));
    tbl.push_back(mk(1,  5, 1, 0, 8'h00, 5'b00001));
    tbl.push_back(mk(0,  1, 1, 1, 8'h00, 5'b00001));
    tbl.push_back(mk(0,  1, 1, 0, 8'h00, 5'b00101));
    tbl.push_back(mk(0,  1, 1, 0, 8'h00, 5'b10000));
    tbl.push_back(mk(0,  4, 1, 0, 8'hFF, 5'b00000));
    tbl.push_back(mk(0,  8, 1, 0, 8'h00, 5'b00000));
    tbl.push_back(mk(0,  1, 1, 1, 8'h00, 5'b00000));
    tbl.push_back(mk(0,  2, 1, 0, 8'h00, 5'b00100));
    tbl.push_back(mk(0, 84, 1, 0, 8'h00, 5'b00101));
    tbl.push_back(mk(0,  1, 1, 0, 8'h00, 5'b10000));
    tbl.push_back(mk(0,  1, 1, 0, 8'h00, 5'b00000));

    foreach (tbl[i]) begin
      if (tbl[i].rst_before) do_reset();
      for (int k = 0; k < tbl[i].n; k++) begin
        en = tbl[i].en; fd = tbl[i].fd; busy = tbl[i].busy;
        check($sformatf("vec row %0d outs", i), outs(), int'(tbl[i].exp));
        tick();
      end
    end

    // Overwrite: frames at 10, 12, 14 while busy; the last two are drops.
    do_reset();
    en = 1'b1;
    for (int t = 0; t < 131; t++) begin
      fd   = (t == 5 || t == 10 || t == 12 || t == 14);
      busy = (t >= 8 && t <= 29) ? 8'hFF : 8'h00;
      tick();
    end
    fd = 1'b0; busy = 8'h00;
    check("ovw refresh count", q_ref.size(), 2);
    if (q_ref.size() == 2) check("ovw second refresh cycle", q_ref[1], 107);
    check("ovw drop count", q_drop.size(), 2);
    if (q_drop.size() == 2) begin
      check("ovw drop0 cycle", q_drop[0], 13);
      check("ovw drop1 cycle", q_drop[1], 15);
    end

    // Keep-alive: one frame at 2, then silence for 200 cycles.
    do_reset();
    en = 1'b1;
    for (int t = 0; t < 200; t++) begin
      fd = (t == 2);
      tick();
    end
    fd = 1'b0;
    begin
      int exp_t[4];
      bit exp_k[4];
      exp_t[0] = 4;   exp_k[0] = 1'b0;
      exp_t[1] = 60;  exp_k[1] = 1'b1;
      exp_t[2] = 116; exp_k[2] = 1'b1;
      exp_t[3] = 172; exp_k[3] = 1'b1;
      check("ka refresh count", q_kt.size(), 4);
      if (q_kt.size() == 4) begin
        for (int i = 0; i < 4; i++) begin
          check($sformatf("ka refresh %0d cycle", i), q_kt[i], exp_t[i]);
          check($sformatf("ka refresh %0d flag", i), int'(q_kk[i]), int'(exp_k[i]));
        end
      end
    end
    check("no-ka refresh count", q_ref.size(), 1);
    if (q_ref.size() == 1) check("no-ka refresh cycle", q_ref[0], 4);

    // Enable gating, then reset during SEND discards the in-flight state.
    do_reset();
    for (int t = 0; t < 150; t++) begin
      en   = (t >= 20);
      fd   = (t == 2);
      busy = (t >= 22 && t <= 25) ? 8'hFF : 8'h00;
      rst  = (t == 25);
      if (t == 20) begin
        check("gated pending", int'(pending), 1);
        check("gated refresh count", q_ref.size(), 0);
      end
      if (t == 26) check("post-reset outs", outs(), int'(5'b00001));
      tick();
    end
    rst = 1'b0; busy = 8'h00;
    check("enable refresh count", q_ref.size(), 1);
    if (q_ref.size() == 1) check("enable refresh cycle", q_ref[0], 21);

    // Busy re-assert in LATCH restarts the full latch gap.
    do_reset();
    en = 1'b1;
    for (int t = 0; t < 26; t++) begin
      fd   = (t == 2);
      busy = (t == 9) ? 8'h08 : 8'h00;
      if (t >= 5) check($sformatf("relatch idle t%0d", t), int'(idle), (t >= 21) ? 1 : 0);
      tick();
    end
    fd = 1'b0; busy = 8'h00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
